mem_port_arbiter: RTL and testbench

Shares one single-ported backing memory between the core's instruction-fetch side (read-only) and data side (load/store). Sits between mipsCore's iCache/dCache request ports and the unified memory model. Arbitration is round-robin with a multi-cycle req/ack handshake on both sides. A watchdog terminates memory transactions that hang.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types, constants and grant helper for the memory port arbiter
package mips_pkg;

  // Arbiter sequencing: wait for a requester, drive memory, return the response
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  // Which side owns the current memory transaction
  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  // Read data handed back when the memory never answers
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Round-robin pick: a lone requester wins outright, under contention the
  // side that was not served last goes next
  function automatic owner_t pickGrant(
    input logic   iReq,
    input logic   dReq,
    input owner_t lastGrant
  );
    if (iReq && dReq) begin
      return (lastGrant == OWN_I) ? OWN_D : OWN_I;
    end else if (iReq) begin
      return OWN_I;
    end else begin
      return OWN_D;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter in front of a single-ported memory
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter int             TIMEOUT  = 16,
  parameter logic [DW-1:0]  ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,

  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  // A zero TIMEOUT disables the watchdog; keep a one-bit counter so the
  // declaration stays legal in that case
  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t    state;
  owner_t        lastGrant;   // doubles as the owner of the transaction in flight
  owner_t        grantSide;
  logic [CW-1:0] wdCnt;
  logic          timeoutHit;

  assign grantSide  = pickGrant(i_req, d_req, lastGrant);
  assign timeoutHit = (TIMEOUT != 0) && (wdCnt == LIMIT);

  // Single FSM: grant in IDLE, hold the memory request in ISSUE under the
  // watchdog, pulse the owner's ack in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lastGrant <= OWN_D;
      wdCnt     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            lastGrant <= grantSide;
            wdCnt     <= '0;
            mem_req   <= 1'b1;
            if (grantSide == OWN_I) begin
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end else begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          // A late ack on the limit cycle still counts as a good completion
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (lastGrant == OWN_I) begin
              i_ack   <= 1'b1;
              i_err   <= 1'b0;
              i_rdata <= mem_rdata;
            end else begin
              d_ack <= 1'b1;
              d_err <= 1'b0;
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end else if (timeoutHit) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (lastGrant == OWN_I) begin
              i_ack   <= 1'b1;
              i_err   <= 1'b1;
              i_rdata <= ERR_DATA;
            end else begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
              if (!mem_we) begin
                d_rdata <= ERR_DATA;
              end
            end
          end else begin
            wdCnt <= wdCnt + 1'b1;
          end
        end

        RESP: begin
          i_ack <= 1'b0;
          i_err <= 1'b0;
          d_ack <= 1'b0;
          d_err <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERRD    = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  mem_port_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          latMode  = 1;     // <0: random latency per transaction
  bit          strayEn  = 1'b0;
  bit          respFixed = 1'b0;
  logic [31:0] respData = '0;
  int          respCnt  = -1;

  function automatic int pickLat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 4);
    else if (r == 6) return TIMEOUT - 2;
    else if (r == 7) return TIMEOUT - 1;
    else if (r == 8) return TIMEOUT;
    else return 40;
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        mem_ack = 1'b0;
        respCnt = -1;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (respCnt < 0) respCnt = (latMode < 0) ? pickLat() : latMode;
        if (respCnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = respFixed ? respData : $urandom;
          respCnt   = -1;
        end else begin
          respCnt--;
        end
      end else begin
        respCnt = -1;
        if (strayEn && $urandom_range(0, 7) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  // Each negedge sees one cycle's outputs plus the inputs the next edge samples.
  bit          mReqLast, mAckLast, mDone, expIack, expDack, expErr;
  bit          lastGrantD;   // 0 = fetch side served last, 1 = data side
  bit          ownD;
  logic [31:0] txnAddr, txnWdata, mIrdata, mDrdata;
  bit          txnWe;
  int          issueCycles;
  bit          pIreq, pDreq, pDwe;
  logic [31:0] pIaddr, pDaddr, pDwdata;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mReqLast = 0; mAckLast = 0; mDone = 0; expIack = 0; expDack = 0; expErr = 0;
        lastGrantD = 1; mIrdata = '0; mDrdata = '0; pIreq = 0; pDreq = 0; issueCycles = 0;
      end else begin
        bit expStart, expMemReq, done, nI, nD, err;
        logic [31:0] data;
        chk("i_ack", i_ack, expIack);
        chk("d_ack", d_ack, expDack);
        chk("ack_overlap", i_ack & d_ack, 0);
        chk("i_err", i_err, expIack & expErr);
        chk("d_err", d_err, expDack & expErr);
        chk("i_rdata", i_rdata, mIrdata);
        chk("d_rdata", d_rdata, mDrdata);

        expStart  = !mReqLast && !mAckLast && (pIreq || pDreq);
        expMemReq = expStart || (mReqLast && !mDone);
        chk("mem_req", mem_req, expMemReq);
        if (expStart) begin
          ownD        = (pIreq && pDreq) ? !lastGrantD : !pIreq;
          lastGrantD  = ownD;
          txnAddr     = ownD ? pDaddr : pIaddr;
          txnWe       = ownD ? pDwe : 1'b0;
          txnWdata    = pDwdata;
          issueCycles = 0;
        end
        done = 0; nI = 0; nD = 0; err = 0; data = '0;
        if (expMemReq) begin
          issueCycles++;
          chk("mem_addr", mem_addr, txnAddr);
          chk("mem_we", mem_we, txnWe);
          if (txnWe) chk("mem_wdata", mem_wdata, txnWdata);
          if (mem_ack) begin
            done = 1; err = 0; data = mem_rdata;
          end else if (TIMEOUT != 0 && issueCycles == TIMEOUT) begin
            done = 1; err = 1; data = ERRD;
          end
          if (done) begin
            if (!ownD) begin
              nI = 1; mIrdata = data;
            end else begin
              nD = 1;
              if (!txnWe) mDrdata = data;
            end
            expErr = err;
          end
        end
        mAckLast = expIack | expDack;
        expIack  = nI;
        expDack  = nD;
        mReqLast = expMemReq;
        mDone    = done;
        pIreq = i_req; pDreq = d_req; pDwe = d_we;
        pIaddr = i_addr; pDaddr = d_addr; pDwdata = d_wdata;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_req(input bit side, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output bit err, output int memCycles,
                        output logic [31:0] firstAddr, output bit firstWe, output logic [31:0] firstWdata);
    bit got;
    got = 0; memCycles = 0; rdata = '0; err = 0; firstAddr = '0; firstWe = 0; firstWdata = '0;
    @(posedge clk); #1;
    if (!side) begin
      i_req = 1; i_addr = addr;
    end else begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (memCycles == 0) begin
          firstAddr = mem_addr; firstWe = mem_we; firstWdata = mem_wdata;
        end
        memCycles++;
      end
      if (side ? d_ack : i_ack) begin
        got = 1;
        rdata = side ? d_rdata : i_rdata;
        err   = side ? d_err : i_err;
      end
    end
    chk("directed_ack_wait", got, 1);
    @(posedge clk); #1;
    if (!side) i_req = 0; else d_req = 0;
  endtask

  task automatic rand_side(input bit side, input int n);
    bit got;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        if (!side) i_req = 0; else d_req = 0;
        repeat (gap) @(posedge clk);
        #1;
      end
      if (!side) begin
        i_req = 1; i_addr = $urandom;
      end else begin
        d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
      end
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(posedge clk); #1;
        got = side ? d_ack : i_ack;
      end
      chk(side ? "rand_d_ack_wait" : "rand_i_ack_wait", got, 1);
    end
    if (!side) i_req = 0; else d_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd, fa, fw;
    bit          er, fwe, gotI, gotD;
    int          mc, n, acksSeen;
    int          order[4];

    rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    #1 rst = 0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // contention from reset: I first, then strict alternation
    latMode = 1;
    @(posedge clk); #1;
    i_addr = 32'h10; d_addr = 32'h20; d_we = 0;
    i_req = 1; d_req = 1;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (i_ack && n < 4) begin order[n] = 0; n++; end
      if (d_ack && n < 4) begin order[n] = 1; n++; end
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    chk("contend_count", n, 4);
    chk("contend_0_is_i", order[0], 0);
    chk("contend_1_is_d", order[1], 1);
    chk("contend_2_is_i", order[2], 0);
    chk("contend_3_is_d", order[3], 1);

    // fetch with memory answering three cycles after mem_req
    latMode = 3; respFixed = 1; respData = 32'h014B_4820;
    do_req(0, 0, 32'h0000_0040, '0, rd, er, mc, fa, fwe, fw);
    chk("fetch_mem_addr", fa, 32'h40);
    chk("fetch_mem_we", fwe, 0);
    chk("fetch_mem_cycles", mc, 4);
    chk("fetch_rdata", rd, 32'h014B_4820);
    chk("fetch_err", er, 0);

    // data load that the memory never answers
    latMode = 99;
    do_req(1, 0, 32'h200, '0, rd, er, mc, fa, fwe, fw);
    chk("timeout_mem_cycles", mc, TIMEOUT);
    chk("timeout_err", er, 1);
    chk("timeout_rdata", rd, 32'hDEAD_BEEF);

    // store right after the timeout: normal service, load data untouched
    latMode = 1;
    do_req(1, 1, 32'h104, 32'd20, rd, er, mc, fa, fwe, fw);
    chk("store_mem_we", fwe, 1);
    chk("store_mem_wdata", fw, 32'd20);
    chk("store_mem_addr", fa, 32'h104);
    chk("store_err", er, 0);
    chk("store_d_rdata_kept", rd, 32'hDEAD_BEEF);

    // ack arriving on the last watchdog cycle wins
    latMode = TIMEOUT - 1; respData = 32'h1234_5678;
    do_req(0, 0, 32'h300, '0, rd, er, mc, fa, fwe, fw);
    chk("limit_mem_cycles", mc, TIMEOUT);
    chk("limit_err", er, 0);
    chk("limit_rdata", rd, 32'h1234_5678);
    respFixed = 0;

    // asynchronous reset in the middle of ISSUE
    latMode = 99;
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h400;
    for (int c = 0; c < 10 && !mem_req; c++) @(negedge clk);
    chk("abort_issue_reached", mem_req, 1);
    repeat (2) @(posedge clk);
    #3 rst = 0;
    #1;
    chk("abort_mem_req_async", mem_req, 0);
    chk("abort_no_ack", {i_ack, d_ack}, 0);
    i_req = 1; i_addr = 32'h80;
    repeat (2) @(posedge clk);
    #1 rst = 1; latMode = 1;
    acksSeen = 0;
    for (int c = 0; c < 20 && !mem_req; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) acksSeen++;
    end
    chk("abort_acks_before_grant", acksSeen, 0);
    chk("abort_regrant_is_i", mem_addr, 32'h80);
    gotI = 0; gotD = 0;
    for (int c = 0; c < 100 && !(gotI && gotD); c++) begin
      @(posedge clk); #1;
      if (i_ack) begin gotI = 1; i_req = 0; end
      if (d_ack) begin
        gotD = 1; d_req = 0;
        chk("abort_d_after_i", gotI, 1);
      end
    end
    chk("abort_both_served", {gotI, gotD}, 2'b11);

    // randomized traffic with random latency, timeouts and stray acks
    latMode = -1; strayEn = 1;
    fork
      rand_side(0, 40);
      rand_side(1, 40);
    join
    strayEn = 0;
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
